// File: rtl/frame_timing_pkg.sv
// Shared types for the UART-style frame timing sequencer.
// Holds the FSM state encoding and the bit index width.
package frame_timing_pkg;

    localparam int BIT_IDX_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SYNC_LOAD,
        SYNC_CNT,
        BIT_LOAD,
        BIT_CNT,
        STOP_CNT,
        DONE
    } ftseq_state_t;

endpackage

// File: rtl/frame_timing_sequencer.sv
// Walks an external loadable counter through start-sync, data bits and stop,
// turning its rollover pulses into bit-centre sample strobes and frame_done.
module frame_timing_sequencer
    import frame_timing_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_BITS     = 8,
    parameter int PERIOD       = 8,
    parameter int HALF         = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    ctr_rollover_flag,
    output logic                    ctr_clear,
    output logic                    ctr_enable,
    output logic [NUM_CNT_BITS-1:0] ctr_start_val,
    output logic [NUM_CNT_BITS-1:0] ctr_rollover_val,
    output logic                    sample_strobe,
    output logic [BIT_IDX_W-1:0]    bit_index,
    output logic                    busy,
    output logic                    frame_done
);

    localparam logic [NUM_CNT_BITS-1:0] RV_PERIOD = NUM_CNT_BITS'(PERIOD);
    localparam logic [NUM_CNT_BITS-1:0] RV_HALF   = NUM_CNT_BITS'(HALF);
    localparam logic [BIT_IDX_W-1:0]    LAST_BIT  = BIT_IDX_W'(NUM_BITS - 1);

    ftseq_state_t         state_q, state_d;
    logic [BIT_IDX_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BIT_IDX_W-1:0] bit_index_q, bit_index_d;
    logic                 strobe_q, strobe_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        bit_index_d      = bit_index_q;
        strobe_d         = 1'b0;
        done_d           = 1'b0;
        ctr_clear        = 1'b0;
        ctr_enable       = 1'b0;
        ctr_rollover_val = RV_PERIOD;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) state_d = SYNC_LOAD;
            end
            SYNC_LOAD: begin
                ctr_clear        = 1'b1;
                ctr_rollover_val = RV_HALF;
                state_d          = SYNC_CNT;
            end
            SYNC_CNT: begin
                ctr_enable       = 1'b1;
                ctr_rollover_val = RV_HALF;
                if (ctr_rollover_flag) begin
                    state_d   = BIT_LOAD;
                    bit_cnt_d = '0;
                end
            end
            BIT_LOAD: begin
                ctr_clear = 1'b1;
                state_d   = BIT_CNT;
            end
            BIT_CNT: begin
                ctr_enable = 1'b1;
                if (ctr_rollover_flag) begin
                    strobe_d    = 1'b1;
                    bit_index_d = bit_cnt_q;
                    if (bit_cnt_q == LAST_BIT) state_d = STOP_CNT;
                    else bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            STOP_CNT: begin
                ctr_enable = 1'b1;
                if (ctr_rollover_flag) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                bit_index_d = '0;
            end
            default: begin
                state_d     = IDLE;
                bit_index_d = '0;
            end
        endcase

        // Abort overrides everything, including a same-cycle rollover.
        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            ctr_clear   = 1'b1;
            strobe_d    = 1'b0;
            done_d      = 1'b0;
            bit_index_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            bit_index_q <= '0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_index_q <= bit_index_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
        end
    end

    assign ctr_start_val = '0;
    assign sample_strobe = strobe_q;
    assign bit_index     = bit_index_q;
    assign frame_done    = done_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_frame_timing_sequencer.sv
// Directed bench for frame_timing_sequencer with a behavioural counter
// that flags after every ctr_rollover_val enabled cycles following a clear.
module tb_frame_timing_sequencer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sflag = 1'b0;
    logic       mflag;
    logic [3:0] mcnt;
    logic       ctr_rollover_flag;
    logic       ctr_clear, ctr_enable;
    logic [3:0] ctr_start_val, ctr_rollover_val;
    logic       sample_strobe, busy, frame_done;
    logic [7:0] bit_index;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctr_rollover_flag = mflag | sflag;

    frame_timing_sequencer #(
        .NUM_CNT_BITS(4), .NUM_BITS(8), .PERIOD(8), .HALF(4)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .ctr_rollover_flag(ctr_rollover_flag),
        .ctr_clear(ctr_clear), .ctr_enable(ctr_enable),
        .ctr_start_val(ctr_start_val),
        .ctr_rollover_val(ctr_rollover_val),
        .sample_strobe(sample_strobe), .bit_index(bit_index),
        .busy(busy), .frame_done(frame_done)
    );

    // Counter model: clear wins, flag pulses after rv enabled edges.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mcnt  <= 4'd0;
            mflag <= 1'b0;
        end else if (ctr_clear) begin
            mcnt  <= 4'd0;
            mflag <= 1'b0;
        end else if (ctr_enable) begin
            if (mcnt + 4'd1 == ctr_rollover_val) begin
                mcnt  <= 4'd0;
                mflag <= 1'b1;
            end else begin
                mcnt  <= mcnt + 4'd1;
                mflag <= 1'b0;
            end
        end else begin
            mflag <= 1'b0;
        end
    end

    // in = {start, abort, sflag}; ex = {busy, strobe, done, clear, enable}
    typedef struct {
        int         cyc;
        logic [2:0] in;
        logic [4:0] ex;
        logic [7:0] idx;
        logic [3:0] rv;
    } vec_t;

    vec_t vq[$];

    function automatic void row(int c, logic [2:0] in, logic [4:0] ex,
                                int idx, int rv);
        vec_t v;
        v.cyc = c;
        v.in  = in;
        v.ex  = ex;
        v.idx = 8'(idx);
        v.rv  = 4'(rv);
        vq.push_back(v);
    endfunction

    function automatic logic [20:0] outs();
        return {busy, sample_strobe, frame_done, ctr_clear, ctr_enable,
                bit_index, ctr_rollover_val, ctr_start_val};
    endfunction

    task automatic chk(string nm, int c, logic [20:0] got, logic [20:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s c%0d: got b/s/d/cl/en=%b idx=%0d rv=%0d sv=%0d, want %b idx=%0d rv=%0d sv=%0d",
                     nm, c, got[20:16], got[15:8], got[7:4], got[3:0],
                     want[20:16], want[15:8], want[7:4], want[3:0]);
        end
    endtask

    task automatic run_vecs(string nm, int ncyc, int es, int ed);
        int r = 0;
        int ns = 0;
        int nd = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            if (r < vq.size() && vq[r].cyc == c)
                {start, abort, sflag} = vq[r].in;
            else
                {start, abort, sflag} = 3'b000;
            @(negedge clk);
            ns += int'(sample_strobe);
            nd += int'(frame_done);
            if (r < vq.size() && vq[r].cyc == c) begin
                chk(nm, c, outs(), {vq[r].ex, vq[r].idx, vq[r].rv, 4'd0});
                r++;
            end
        end
        {start, abort, sflag} = 3'b000;
        checks++;
        if (ns != es || nd != ed) begin
            errors++;
            $display("FAIL %s totals: got strobes=%0d dones=%0d, want strobes=%0d dones=%0d",
                     nm, ns, nd, es, ed);
        end
        vq.delete();
    endtask

    // Clean frame from cycle 0: strobes at 17+8k, done at 81, idle at 82.
    function automatic void fill_frame();
        row(0,  3'b100, 5'b00000, 0, 8);
        row(1,  3'b000, 5'b10010, 0, 4);
        row(2,  3'b000, 5'b10001, 0, 4);
        row(6,  3'b000, 5'b10001, 0, 4);
        row(7,  3'b000, 5'b10010, 0, 8);
        row(8,  3'b000, 5'b10001, 0, 8);
        row(16, 3'b000, 5'b10001, 0, 8);
        row(17, 3'b000, 5'b11001, 0, 8);
        row(18, 3'b000, 5'b10001, 0, 8);
        for (int k = 1; k < 8; k++) begin
            row(17 + 8 * k, 3'b000, 5'b11001, k, 8);
            row(18 + 8 * k, 3'b000, 5'b10001, k, 8);
        end
        row(80, 3'b000, 5'b10001, 7, 8);
        row(81, 3'b000, 5'b10100, 7, 8);
        row(82, 3'b000, 5'b00000, 0, 8);
        row(85, 3'b000, 5'b00000, 0, 8);
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset", 0, outs(), {5'b00000, 8'd0, 4'd8, 4'd0});
        n_rst = 1'b1;

        row(0, 3'b000, 5'b00000, 0, 8);
        row(1, 3'b001, 5'b00000, 0, 8);
        row(2, 3'b011, 5'b00000, 0, 8);
        row(3, 3'b000, 5'b00000, 0, 8);
        row(4, 3'b001, 5'b00000, 0, 8);
        row(5, 3'b000, 5'b00000, 0, 8);
        run_vecs("idle_stray", 6, 0, 0);

        fill_frame();
        run_vecs("frame", 86, 8, 1);

        row(0,  3'b100, 5'b00000, 0, 8);
        row(17, 3'b000, 5'b11001, 0, 8);
        row(25, 3'b000, 5'b11001, 1, 8);
        row(26, 3'b000, 5'b10001, 1, 8);
        row(28, 3'b010, 5'b10011, 1, 8);
        row(29, 3'b000, 5'b00000, 0, 8);
        row(33, 3'b000, 5'b00000, 0, 8);
        row(40, 3'b000, 5'b00000, 0, 8);
        run_vecs("abort_bit2", 45, 2, 0);

        row(0,  3'b100, 5'b00000, 0, 8);
        row(17, 3'b000, 5'b11001, 0, 8);
        row(24, 3'b011, 5'b10011, 0, 8);
        row(25, 3'b000, 5'b00000, 0, 8);
        row(33, 3'b000, 5'b00000, 0, 8);
        run_vecs("abort_flag", 40, 1, 0);

        row(0,   3'b100, 5'b00000, 0, 8);
        row(1,   3'b000, 5'b10010, 0, 4);
        row(5,   3'b100, 5'b10001, 0, 4);
        row(17,  3'b000, 5'b11001, 0, 8);
        row(40,  3'b100, 5'b10001, 2, 8);
        row(41,  3'b000, 5'b11001, 3, 8);
        row(73,  3'b000, 5'b11001, 7, 8);
        row(81,  3'b100, 5'b10100, 7, 8);
        row(82,  3'b100, 5'b00000, 0, 8);
        row(83,  3'b000, 5'b10010, 0, 4);
        row(84,  3'b000, 5'b10001, 0, 4);
        row(99,  3'b000, 5'b11001, 0, 8);
        row(163, 3'b000, 5'b10100, 7, 8);
        row(164, 3'b000, 5'b00000, 0, 8);
        run_vecs("busy_start", 170, 16, 2);

        fill_frame();
        run_vecs("rst_mid", 60, 6, 0);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_async", 60, outs(), {5'b00000, 8'd0, 4'd8, 4'd0});
        @(negedge clk);
        n_rst = 1'b1;

        fill_frame();
        run_vecs("after_rst", 86, 8, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
